wb_seg_stat_reg: RTL and testbench
==================================

Name: wb_seg_stat_reg

Overview:
- Parametrised MEM/WB write-back segment register.
- Selects ALU or load data, sign/zero-extends loads from the raw cache word, and carries the CSR result. Honours bubbleW (hold) and flushW (zero).
- Adds saturating data-cache statistics counters (accesses, misses, miss-stall cycles, loads) with a registered readout port.
- Sits between the data cache and the register-file write port.

Parameters:
XLEN, 32, datapath width; legal values are 32 only in this revision; all data ports use it.
CNT_W, 32, width of each statistics counter; legal range 8..64.

Ports:
clk  in  1  clock; all state updates on rising edge.
rst  in  1  reset, asynchronous, active-high; clears every register and counter.
bubbleW  in  1  hold WB stage outputs.
flushW  in  1  zero WB stage outputs.
wb_select  in  1  1 = write back load data, 0 = write back addr (ALU result).
load_type  in  3  0 = none, 1 = LB, 2 = LH, 3 = LW, 4 = LBU, 5 = LHU; 6 and 7 behave as LW.
addr  in  XLEN  ALU result / data-cache byte address.
mem_rd_data  in  XLEN  raw word returned by the data cache, valid in the cycle after the request.
CSR_result_MEM  in  XLEN  CSR value from MEM.
rd_req  in  1  data-cache read request (level).
wr_req  in  1  data-cache write request (level).
cache_miss  in  1  data-cache miss/stall indication (level).
stat_sel  in  2  counter select: 0 = accesses, 1 = misses, 2 = stall cycles, 3 = loads.
stat_clr  in  1  synchronous clear of all counters.
data_WB  out  XLEN  write-back data.
CSRWB  out  XLEN  write-back CSR value.
stat_value  out  CNT_W  selected counter, registered.

Behaviour:
- Reset (async, rst=1): all stage registers cleared.
  - data_WB = 0, CSRWB = 0, stat_value = 0.
  - All counters and edge-detect flops = 0.
- Stage capture: each edge registers wb_select, load_type, addr, CSR_result_MEM and flush/bubble flags.
  - mem_rd_data is consumed combinationally against the registered addr[1:0] and load_type.
  - Latency is one cycle from MEM inputs to data_WB/CSRWB.
- Output priority, evaluated on the registered flags: bubble over flush over normal.
  - bubble_ff=1: data_WB and CSRWB hold their previous values; holds any number of cycles.
  - flush_ff=1 (and no bubble): data_WB = 0, CSRWB = 0.
  - Normal: data_WB = wb_select_ff ? extended load : addr_ff; CSRWB = CSR result.
- Load extension:
  - LB/LBU take byte addr[1:0] and sign/zero-extend it.
  - LH/LHU take half [15:0] when addr[1]=0, else [31:16]; addr[0] is ignored and misaligned halves raise no error.
  - LW passes the word; type 0 outputs 0.
- Edge detection: registered copies req_d = rd_req|wr_req, miss_d = cache_miss and rd_d = rd_req.
- Counter updates:
  - Accesses: +1 when (rd_req|wr_req)=1 and req_d=0, so a multi-cycle stalled request counts once.
  - Misses: +1 when cache_miss=1 and miss_d=0.
  - Stall cycles: +1 every cycle cache_miss=1.
  - Loads: +1 when rd_req=1 and rd_d=0.
- Saturation: every counter stops at 2^CNT_W−1 and never wraps.
- stat_clr: clears all counters to 0 on the edge. Clear wins over a simultaneous increment; the edge-detect flops still update.
- flushW and bubbleW never affect counters or edge-detect flops.
- stat_value: registered mux of the counter values before update.
  - One-cycle latency from stat_sel change; reflects the counter value of the previous edge.
- Reset mid-stall: counters zeroed and edge flops cleared. If cache_miss is still 1 on the first edge after rst falls, it counts as a new miss.

Optional Feature:
WB_STAT_EN
- Defined: the four counters, edge-detect flops and stat_value register are present as specified.
- Undefined: no counter logic is generated.
  - stat_value is constant 0.
  - stat_sel, stat_clr, rd_req, wr_req and cache_miss are unused.
  - data_WB/CSRWB behaviour is unchanged.

Test Plan:
- Reset, then LB path: addr=0x1003, wb_select=1, load_type=1, mem_rd_data=0x80FF_1234 -> data_WB=0xFFFF_FF80 one cycle later. Same with load_type=4 -> 0x0000_0080.
- ALU path, bubble then flush: wb_select=0, addr=0x0000_00AA, CSR_result_MEM=0x5. Next cycle bubbleW=1 with addr=0x77 -> data_WB stays 0xAA, CSRWB stays 0x5. Then flushW=1 -> both 0.
- Stalled read: rd_req=1 and cache_miss=1 for 5 cycles, then cache_miss=0 for 1 cycle, then rd_req=0 -> accesses=1, misses=1, stalls=5, loads=1.
- Saturation with CNT_W=8: 300 separate single-cycle wr_req pulses -> accesses reads 0xFF; misses=0, loads=0.
- stat_clr asserted in the same cycle as a new miss edge -> all counters 0 afterwards. A miss held high into the next cycle does not count again; stall counter = 1.
- Async reset mid-stall: rst pulse for 1 ns between edges while cache_miss=1 -> outputs and counters 0 immediately. First edge after release -> misses=1, stalls=1.

Source files
------------

// File: rtl/wb_seg_stat_reg.sv
// MEM/WB write-back segment register: load extension, bubble/flush handling and
// optional data-cache statistics counters, enabled by defining WB_STAT_EN.
module wb_seg_stat_reg #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bubbleW,
  input  logic             flushW,
  input  logic             wb_select,
  input  logic [2:0]       load_type,
  input  logic [XLEN-1:0]  addr,
  input  logic [XLEN-1:0]  mem_rd_data,
  input  logic [XLEN-1:0]  CSR_result_MEM,
  input  logic             rd_req,
  input  logic             wr_req,
  input  logic             cache_miss,
  input  logic [1:0]       stat_sel,
  input  logic             stat_clr,
  output logic [XLEN-1:0]  data_WB,
  output logic [XLEN-1:0]  CSRWB,
  output logic [CNT_W-1:0] stat_value
);

  logic            wb_select_reg;
  logic [2:0]      load_type_reg;
  logic [XLEN-1:0] addr_reg;
  logic [XLEN-1:0] csr_reg;
  logic            flush_reg;
  logic            bubble_reg;
  logic [XLEN-1:0] data_hold_reg;
  logic [XLEN-1:0] csr_hold_reg;
  logic [7:0]      byte_sel;
  logic [15:0]     half_sel;
  logic [XLEN-1:0] load_ext;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wb_select_reg <= 1'b0;
      load_type_reg <= 3'd0;
      addr_reg      <= '0;
      csr_reg       <= '0;
      flush_reg     <= 1'b0;
      bubble_reg    <= 1'b0;
      data_hold_reg <= '0;
      csr_hold_reg  <= '0;
    end else begin
      wb_select_reg <= wb_select;
      load_type_reg <= load_type;
      addr_reg      <= addr;
      csr_reg       <= CSR_result_MEM;
      flush_reg     <= flushW;
      bubble_reg    <= bubbleW;
      // Remember what was presented so a bubble can replay it indefinitely.
      data_hold_reg <= data_WB;
      csr_hold_reg  <= CSRWB;
    end
  end

  // The cache word arrives one cycle after the request, so it is aligned
  // against the registered address rather than the live one.
  always_comb begin
    byte_sel = 8'h00;
    case (addr_reg[1:0])
      2'd0: byte_sel = mem_rd_data[7:0];
      2'd1: byte_sel = mem_rd_data[15:8];
      2'd2: byte_sel = mem_rd_data[23:16];
      2'd3: byte_sel = mem_rd_data[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_reg[1] ? mem_rd_data[31:16] : mem_rd_data[15:0];
    case (load_type_reg)
      3'd0:    load_ext = '0;
      3'd1:    load_ext = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      3'd2:    load_ext = {{(XLEN-16){half_sel[15]}}, half_sel};
      3'd4:    load_ext = {{(XLEN-8){1'b0}}, byte_sel};
      3'd5:    load_ext = {{(XLEN-16){1'b0}}, half_sel};
      default: load_ext = mem_rd_data;
    endcase
  end

  always_comb begin
    data_WB = '0;
    CSRWB   = '0;
    if (bubble_reg) begin
      data_WB = data_hold_reg;
      CSRWB   = csr_hold_reg;
    end else if (!flush_reg) begin
      data_WB = wb_select_reg ? load_ext : addr_reg;
      CSRWB   = csr_reg;
    end
  end

`ifdef WB_STAT_EN
  logic             req_d;
  logic             miss_d;
  logic             rd_d;
  logic [3:0]       inc;
  logic [CNT_W-1:0] cnt [4];

  // Index order matches stat_sel: accesses, misses, stall cycles, loads.
  assign inc[0] = (rd_req | wr_req) & ~req_d;
  assign inc[1] = cache_miss & ~miss_d;
  assign inc[2] = cache_miss;
  assign inc[3] = rd_req & ~rd_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_d  <= 1'b0;
      miss_d <= 1'b0;
      rd_d   <= 1'b0;
    end else begin
      req_d  <= rd_req | wr_req;
      miss_d <= cache_miss;
      rd_d   <= rd_req;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cnt
      logic [CNT_W-1:0] count_reg;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          count_reg <= '0;
        end else if (stat_clr) begin
          count_reg <= '0;
        end else if (inc[gi] && (count_reg != {CNT_W{1'b1}})) begin
          count_reg <= count_reg + 1'b1;
        end
      end
      assign cnt[gi] = count_reg;
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_value <= '0;
    end else begin
      stat_value <= cnt[stat_sel];
    end
  end
`else
  logic unused_stat_inputs;
  assign unused_stat_inputs = ^{stat_sel, stat_clr, rd_req, wr_req, cache_miss};
  assign stat_value = '0;
`endif

endmodule

// File: tb/tb_wb_seg_stat_reg.sv
// Scoreboard bench for wb_seg_stat_reg: a driver predicts each cycle's outputs from a
// behavioural model and queues them; a monitor compares them on the falling edge.
module tb_wb_seg_stat_reg;
  localparam int XLEN = 32;
  localparam int CNT_W = 8;
  localparam int MAXC = (1 << CNT_W) - 1;
`ifdef WB_STAT_EN
  localparam bit STAT_EN = 1'b1;
`else
  localparam bit STAT_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             bubbleW = 1'b0;
  logic             flushW = 1'b0;
  logic             wb_select = 1'b0;
  logic [2:0]       load_type = 3'd0;
  logic [XLEN-1:0]  addr = '0;
  logic [XLEN-1:0]  mem_rd_data = '0;
  logic [XLEN-1:0]  CSR_result_MEM = '0;
  logic             rd_req = 1'b0;
  logic             wr_req = 1'b0;
  logic             cache_miss = 1'b0;
  logic [1:0]       stat_sel = 2'd0;
  logic             stat_clr = 1'b0;
  logic [XLEN-1:0]  data_WB;
  logic [XLEN-1:0]  CSRWB;
  logic [CNT_W-1:0] stat_value;

  wb_seg_stat_reg #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .bubbleW(bubbleW), .flushW(flushW),
    .wb_select(wb_select), .load_type(load_type), .addr(addr),
    .mem_rd_data(mem_rd_data), .CSR_result_MEM(CSR_result_MEM),
    .rd_req(rd_req), .wr_req(wr_req), .cache_miss(cache_miss),
    .stat_sel(stat_sel), .stat_clr(stat_clr),
    .data_WB(data_WB), .CSRWB(CSRWB), .stat_value(stat_value)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0]      data;
    logic [31:0]      csr;
    logic [CNT_W-1:0] stat;
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int failures = 0;

  // Reference model state: event counts (already saturated), previous request
  // levels seen at a clock edge, and the outputs last presented.
  int          cnt[4];
  bit          p_req, p_miss, p_rd;
  logic [31:0] prev_data, prev_csr;

  function automatic logic [31:0] load_val(int lt, logic [31:0] a, logic [31:0] w);
    int unsigned sh;
    logic [31:0] b, h;
    sh = 8 * int'(a[1:0]);
    b  = (w >> sh) & 32'hFF;
    h  = (w >> (a[1] ? 16 : 0)) & 32'hFFFF;
    case (lt)
      0: return 32'd0;
      1: return (b >= 32'd128) ? b - 32'd256 : b;
      2: return (h >= 32'd32768) ? h - 32'd65536 : h;
      4: return b;
      5: return h;
      default: return w;
    endcase
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    p_req = 0; p_miss = 0; p_rd = 0;
    prev_data = '0; prev_csr = '0;
  endtask

  // Applies MEM-stage inputs, advances one edge, then returns mem_next as the
  // cache word for the instruction just captured and predicts the outputs.
  task automatic step(input bit wb, input int lt, input logic [31:0] a, input logic [31:0] csr,
                      input bit bub, input bit fl, input bit rd, input bit wr, input bit miss,
                      input int sel, input bit clr, input logic [31:0] mem_next, input bit do_rst);
    exp_t e;
    int ev[4];
    wb_select = wb; load_type = 3'(lt); addr = a; CSR_result_MEM = csr;
    bubbleW = bub; flushW = fl; rd_req = rd; wr_req = wr; cache_miss = miss;
    stat_sel = 2'(sel); stat_clr = clr;
    @(posedge clk);
    #1;
    mem_rd_data = mem_next;
    e.stat = STAT_EN ? CNT_W'(cnt[sel]) : '0;
    ev[0] = ((rd || wr) && !p_req) ? 1 : 0;
    ev[1] = (miss && !p_miss) ? 1 : 0;
    ev[2] = miss ? 1 : 0;
    ev[3] = (rd && !p_rd) ? 1 : 0;
    for (int i = 0; i < 4; i++) begin
      if (clr) cnt[i] = 0;
      else if (cnt[i] + ev[i] > MAXC) cnt[i] = MAXC;
      else cnt[i] = cnt[i] + ev[i];
    end
    p_req = rd || wr; p_miss = miss; p_rd = rd;
    if (bub) begin
      e.data = prev_data; e.csr = prev_csr;
    end else if (fl) begin
      e.data = '0; e.csr = '0;
    end else begin
      e.data = wb ? load_val(lt, a, mem_next) : a;
      e.csr  = csr;
    end
    prev_data = e.data; prev_csr = e.csr;
    if (do_rst) begin
      #1 rst = 1'b1;
      #1 rst = 1'b0;
      model_reset();
      e.data = '0; e.csr = '0; e.stat = '0;
    end
    sb.push_back(e);
  endtask

  task automatic idle_read(input int sel);
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, sel, 0, 32'h0, 0);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (data_WB !== e.data) begin
          failures++;
          $display("FAIL data_WB got=%h exp=%h t=%0t", data_WB, e.data, $time);
        end
        checks++;
        if (CSRWB !== e.csr) begin
          failures++;
          $display("FAIL CSRWB got=%h exp=%h t=%0t", CSRWB, e.csr, $time);
        end
        checks++;
        if (stat_value !== e.stat) begin
          failures++;
          $display("FAIL stat_value got=%h exp=%h t=%0t", stat_value, e.stat, $time);
        end
      end
    end
  end

  initial begin : driver
    model_reset();
    #12 rst = 1'b0;
    // reset state
    idle_read(0);
    // LB / LBU of byte 3
    step(1, 1, 32'h1003, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h80FF_1234, 0);
    step(1, 4, 32'h1003, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h80FF_1234, 0);
    // halfword loads, upper and lower, with addr[0] set
    step(1, 2, 32'h2003, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h8001_7FFF, 0);
    step(1, 5, 32'h2001, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'h8001_F00F, 0);
    step(1, 7, 32'h2001, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
    step(1, 0, 32'h2001, 32'h0, 0, 0, 0, 0, 0, 0, 0, 32'hDEAD_BEEF, 0);
    // ALU path, then bubble for two cycles, then flush
    step(0, 0, 32'hAA, 32'h5, 0, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 32'h77, 32'h9, 1, 0, 0, 0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 32'h78, 32'h9, 1, 1, 0, 0, 0, 0, 0, 32'h0, 0);
    step(0, 0, 32'h79, 32'h9, 0, 1, 0, 0, 0, 0, 0, 32'h0, 0);
    // stalled read: 5 miss cycles, 1 hit cycle, then release
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 1, 32'h0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 32'h0, 32'h0, 0, 0, 1, 0, 1, 0, 0, 32'h0, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0, 1, 0, 0, 0, 0, 32'h0, 0);
    for (int s = 0; s < 4; s++) idle_read(s);
    // saturation: 300 single-cycle write pulses
    for (int i = 0; i < 300; i++) begin
      step(0, 0, 32'h0, 32'h0, 0, 0, 0, 1, 0, 0, 0, 32'h0, 0);
      idle_read(i % 4);
    end
    for (int s = 0; s < 4; s++) idle_read(s);
    // clear coincident with a new miss edge; miss held one more cycle
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 1, 1, 32'h0, 0);
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0);
    for (int s = 0; s < 4; s++) idle_read(s);
    // async reset mid-stall, miss still high afterwards
    step(0, 0, 32'h33, 32'h44, 0, 0, 1, 0, 1, 1, 0, 32'h0, 0);
    step(0, 0, 32'h34, 32'h45, 0, 0, 1, 0, 1, 2, 0, 32'h0, 1);
    step(0, 0, 32'h0, 32'h0, 0, 0, 0, 0, 1, 1, 0, 32'h0, 0);
    for (int s = 0; s < 4; s++) idle_read(s);
    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 1), $urandom_range(0, 7), $urandom, $urandom,
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           $urandom_range(0, 1), ($urandom_range(0, 2) == 0), ($urandom_range(0, 2) == 0),
           $urandom_range(0, 3), ($urandom_range(0, 40) == 0), $urandom, 0);
    end
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d pending exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
